// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the nibble-serial CLA adder.
// Holds the sequencer state enum, the slice width and an index-width helper.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a slice index able to address n slices (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice.
// Ports: a, b (4b), ci in; s (4b), co (carry out), c3 (carry into bit 3) out.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic                c1;
  logic                c2;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are flattened two-level lookahead terms.
  assign c1 = g[0]
            | (p[0] & ci);

  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & ci);

  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);

  assign co = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: adds two NIBBLES*4-bit words one nibble per cycle.
// Ports: clk, rst_n (async low); in_valid/in_ready + A, B, c_i operands;
//   out_valid/out_ready + Sum, c_o result; busy while not IDLE.
//   Optional ovf (signed overflow) when CLA_SEQ_OVF_EN is defined.
module cla_word_sequencer
  import cla_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  A,
  input  logic [NIBBLE_W*NIBBLES-1:0]  B,
  input  logic                         c_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  Sum,
  output logic                         c_o,
  output logic                         busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic                         ovf
`endif
);

  localparam int IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t state;
  state_t state_nx;

  // Low during reset and until the first edge after release,
  // so in_ready stays low while rst_n is asserted.
  logic alive;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] sum_q;

  logic [IW-1:0] idx;
  logic          cy;
  logic          last;
  logic          accept;

  logic [NIBBLE_W-1:0] s_nib;
  logic                s_co;
  logic                s_c3;

  assign last   = (idx == LAST);
  assign accept = in_valid & in_ready;

  cla4_slice u_slice (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (cy),
    .s  (s_nib),
    .co (s_co),
    .c3 (s_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)    state_nx = ADD;
      ADD:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = alive & (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      idx   <= '0;
      cy    <= 1'b0;
      c_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q <= A;
            b_q <= B;
            idx <= '0;
            cy  <= c_i;
          end
        end
        ADD: begin
          sum_q[idx] <= s_nib;
          cy         <= s_co;
          idx        <= idx + 1'b1;
          if (last) c_o <= s_co;
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SEQ_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == ADD && last) begin
      ovf <= s_co ^ s_c3;
    end
  end
`else
  logic unused_c3;
  assign unused_c3 = s_c3;
`endif

  assign Sum = sum_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: directed table, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_cla_word_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         c_i = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_ready;
  logic         out_valid;
  logic         c_o;
  logic         busy;
  logic [W-1:0] Sum;

  logic       v1 = 1'b0;
  logic       r1 = 1'b0;
  logic       ci1 = 1'b0;
  logic [3:0] a1 = '0;
  logic [3:0] b1 = '0;
  logic       iry1;
  logic       ov1;
  logic       co1;
  logic       bz1;
  logic [3:0] s1;

`ifdef CLA_SEQ_OVF_EN
  logic ovf;
  logic ovf1;
`endif

  cla_word_sequencer #(.NIBBLES(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c_i       (c_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .c_o       (c_o),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  cla_word_sequencer #(.NIBBLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (iry1),
    .A         (a1),
    .B         (b1),
    .c_i       (ci1),
    .out_valid (ov1),
    .out_ready (r1),
    .Sum       (s1),
    .c_o       (co1),
    .busy      (bz1)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    int           hold;
  } vec_t;

  // Reference: plain wide addition; overflow from operand/result signs.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic [W-1:0] s,
                       output logic co, output logic ov);
    logic [W:0] r;
    r  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s  = r[W-1:0];
    co = r[W];
    ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endtask

  task automatic run_op(input string nm,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es,
                        input logic eco, input logic eov,
                        input int hold, input bit inject);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":ready"}, {31'd0, in_ready}, 32'd1);
    if (!in_ready) return;
    A = a;
    B = b;
    c_i = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, ":busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (inject && lat == 1) begin
        in_valid = 1'b1;
        A = ~a;
        B = a ^ b;
        c_i = ~ci;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({nm, ":latency"}, lat, N);
    chk({nm, ":sum"}, {16'd0, Sum}, {16'd0, es});
    chk({nm, ":c_o"}, {31'd0, c_o}, {31'd0, eco});
`ifdef CLA_SEQ_OVF_EN
    chk({nm, ":ovf"}, {31'd0, ovf}, {31'd0, eov});
`else
    if (eov === 1'bx) $display("note: unknown ovf expectation");
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, ":hold_sum"}, {16'd0, Sum}, {16'd0, es});
      chk({nm, ":hold_co"}, {31'd0, c_o}, {31'd0, eco});
      chk({nm, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, ":hold_inrdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, ":post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, ":post_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, ":post_inrdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rci;
    logic [W-1:0] rs;
    logic         rco;
    logic         rov;

    vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 3};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
    vecs[6] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
    vecs[7] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {16'd0, Sum}, 32'd0);
    chk("rst_c_o", {31'd0, c_o}, 32'd0);
    chk("rst_in_ready1", {31'd0, iry1}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_no_edge_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_edge_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
             vecs[i].sum, vecs[i].co, vecs[i].ovf, vecs[i].hold, 1'b0);
    end

    // Single-slice instance: one ADD cycle then DONE.
    a1 = 4'b1110;
    b1 = 4'b1001;
    ci1 = 1'b1;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("n1_valid_early", {31'd0, ov1}, 32'd0);
    @(negedge clk);
    chk("n1_valid", {31'd0, ov1}, 32'd1);
    chk("n1_sum", {28'd0, s1}, 32'd8);
    chk("n1_c_o", {31'd0, co1}, 32'd1);
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    chk("n1_idle", {31'd0, bz1}, 32'd0);

    // Operands offered mid-operation must be ignored.
    run_op("inject", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0,
           1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("inject_no_second", {31'd0, out_valid}, 32'd0);
      chk("inject_idle", {31'd0, busy}, 32'd0);
    end

    // Reset in the second ADD cycle aborts the operation.
    A = 16'h1111;
    B = 16'h2222;
    c_i = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {16'd0, Sum}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("abort_edge_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rci = 1'($urandom);
      model(ra, rb, rci, rs, rco, rov);
      run_op($sformatf("rnd%0d", i), ra, rb, rci, rs, rco, rov,
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
